// File: rtl/ysyx_23060025_axi_rd_arbiter_if.sv
// rtl/ysyx_23060025_axi_rd_arbiter_if.sv - AXI4 read-channel (AR+R) bundle shared by the arbiter's upstream and downstream sides
//
// Parameters
//   NUM  number of ports packed into the bundle (NUM_MST upstream, 1 downstream)
//   AW   address width per port
//   DW   read data width (shared by every port in the bundle)
// Signals (per port i, packed at [i*W +: W])
//   araddr/arvalid/arlen/arsize/arburst  address request, driven by the master side
//   arready                              address accept, driven by the slave side
//   rvalid/rlast/rdata/rresp             read data, driven by the slave side
//   rready                               read data accept, driven by the master side
// Modports
//   master  drives the request and rready
//   slave   drives arready and the read data
interface ysyx_23060025_axi_rd_arbiter_if #(
  parameter int NUM = 1,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NUM*AW-1:0] araddr;
  logic [NUM-1:0]    arvalid;
  logic [NUM-1:0]    arready;
  logic [NUM*8-1:0]  arlen;
  logic [NUM*3-1:0]  arsize;
  logic [NUM*2-1:0]  arburst;
  logic [NUM-1:0]    rvalid;
  logic [NUM-1:0]    rlast;
  logic [NUM-1:0]    rready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;

  modport master (
    output araddr, arvalid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rlast, rdata, rresp
  );

  modport slave (
    input  araddr, arvalid, arlen, arsize, arburst, rready,
    output arready, rvalid, rlast, rdata, rresp
  );
endinterface

// File: rtl/ysyx_23060025_axi_rd_arbiter.sv
// rtl/ysyx_23060025_axi_rd_arbiter.sv - round-robin arbiter sharing one AXI4 read channel between NUM_MST masters
//
// Carries one transaction at a time: arbitration (IDLE), address handshake (ADDR),
// then every beat up to rlast (DATA). Beats are tracked against arlen and a
// mismatch between rlast and the remaining-beat count raises a sticky error.
//
// Parameters
//   NUM_MST     number of read masters (>=2); master 0 wins the first round after reset
//   ADDR_WIDTH  araddr width
//   DATA_WIDTH  rdata width
// Ports
//   clock         system clock
//   reset         asynchronous, active-high reset
//   m             upstream bundle (slave modport), NUM_MST ports: icache refill = 0, LSU = 1
//   s             downstream bundle (master modport), 1 port, to SoC/DRAM
//   grant         one-hot owner of the channel, 0 while idle
//   protocol_err  sticky burst-length error flag
module ysyx_23060025_axi_rd_arbiter #(
  parameter int NUM_MST    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  ysyx_23060025_axi_rd_arbiter_if.slave      m,
  ysyx_23060025_axi_rd_arbiter_if.master     s,
  output logic [NUM_MST-1:0]                 grant,
  output logic                               protocol_err
);

  localparam int IW = $clog2(NUM_MST);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [7:0]    beat_cnt;

  logic               pick_vld;
  logic [NUM_MST-1:0] pick_oh;
  logic [IW-1:0]      grant_idx;
  logic [7:0]         grant_arlen;

  // Round-robin pick: the first requester strictly above rr_ptr wins, otherwise
  // the search wraps to index 0 and runs up to rr_ptr itself. The master that
  // just finished therefore has the lowest priority next round.
  always_comb begin
    pick_vld = 1'b0;
    pick_oh  = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (!pick_vld && (i > int'(rr_ptr)) && m.arvalid[i]) begin
        pick_vld   = 1'b1;
        pick_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MST; i++) begin
      if (!pick_vld && (i <= int'(rr_ptr)) && m.arvalid[i]) begin
        pick_vld   = 1'b1;
        pick_oh[i] = 1'b1;
      end
    end
  end

  // Channel steering from the one-hot grant. Outside ADDR/DATA everything
  // is held at zero so a reset drops every valid/ready at once.
  always_comb begin
    s.araddr    = '0;
    s.arlen     = '0;
    s.arsize    = '0;
    s.arburst   = '0;
    s.rready    = 1'b0;
    m.arready   = '0;
    m.rvalid    = '0;
    m.rlast     = '0;
    grant_idx   = '0;
    grant_arlen = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (grant[i]) begin
        grant_idx   = IW'(i);
        grant_arlen = m.arlen[i*8 +: 8];
        if (state == ADDR) begin
          s.araddr     = m.araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          s.arlen      = m.arlen[i*8 +: 8];
          s.arsize     = m.arsize[i*3 +: 3];
          s.arburst    = m.arburst[i*2 +: 2];
          m.arready[i] = s.arready;
        end
        if (state == DATA) begin
          m.rvalid[i] = s.rvalid;
          m.rlast[i]  = s.rlast;
          s.rready    = m.rready[i];
        end
      end
    end
  end

  assign s.arvalid = (state == ADDR);

  // Data and response are broadcast; each master qualifies them with its own rvalid.
  assign m.rdata = (state == DATA) ? s.rdata : {DATA_WIDTH{1'b0}};
  assign m.rresp = (state == DATA) ? s.rresp : 2'b00;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= IW'(NUM_MST - 1);
      beat_cnt     <= 8'd0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_oh;
            state <= ADDR;
          end
        end
        // The grant is held here until the handshake even if arvalid drops.
        ADDR: begin
          if (s.arready) begin
            beat_cnt <= grant_arlen;
            state    <= DATA;
          end
        end
        DATA: begin
          if (s.rvalid && s.rready) begin
            // rlast must coincide exactly with the remaining count reaching 0:
            // early rlast (cnt!=0) and missing rlast (cnt==0) are both errors.
            if (s.rlast != (beat_cnt == 8'd0)) begin
              protocol_err <= 1'b1;
            end
            if (beat_cnt != 8'd0) begin
              beat_cnt <= beat_cnt - 8'd1;
            end
            // The slave's rlast ends the burst regardless of the count.
            if (s.rlast) begin
              rr_ptr <= grant_idx;
              grant  <= '0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_arbiter.sv
// tb/tb_ysyx_23060025_axi_rd_arbiter.sv - scoreboard bench for the AXI read arbiter
module tb_ysyx_23060025_axi_rd_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NM-1:0] grant;
  logic          protocol_err;

  ysyx_23060025_axi_rd_arbiter_if #(.NUM(NM), .AW(AW), .DW(DW)) mi ();
  ysyx_23060025_axi_rd_arbiter_if #(.NUM(1),  .AW(AW), .DW(DW)) si ();

  ysyx_23060025_axi_rd_arbiter #(
    .NUM_MST   (NM),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .m           (mi),
    .s           (si),
    .grant       (grant),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          mst;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    int          mst;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  ar_t   exp_ar[$];
  beat_t exp_beat[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int bad_ready = 0;
  int beats_seen[NM] = '{0, 0};
  int ar_cyc[NM] = '{0, 0};
  int rlast_cyc[NM] = '{0, 0};
  int stall_cfg = 0;
  int early_last = -1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Expected transaction: AR fields plus beats; data = addr + 4*beat, resp = beat[1:0].
  task automatic push_txn(input int mst, input logic [31:0] addr, input int len,
                          input int nbeats, input bit last_on_final);
    ar_t   a;
    beat_t b;
    a.mst = mst; a.addr = addr; a.len = 8'(len);
    exp_ar.push_back(a);
    for (int k = 0; k < nbeats; k++) begin
      b.mst  = mst;
      b.data = addr + 32'(4 * k);
      b.resp = 2'(k);
      b.last = last_on_final && (k == nbeats - 1);
      exp_beat.push_back(b);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input int len);
    mi.araddr[i*AW +: AW] = addr;
    mi.arlen[i*8 +: 8]    = 8'(len);
    mi.arsize[i*3 +: 3]   = (i == 0) ? 3'd2 : 3'd3;
    mi.arburst[i*2 +: 2]  = (i == 0) ? 2'd1 : 2'd2;
    mi.arvalid[i]         = 1'b1;
  endtask

  task automatic issue(input int i, input logic [31:0] addr, input int len);
    set_req(i, addr, len);
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (mi.arready[i]) begin
        @(posedge clock); #1;
        mi.arvalid[i] = 1'b0;
        return;
      end
    end
    chk("issue_timeout", mi.arvalid[i], 0);
    mi.arvalid[i] = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 600 && !(exp_beat.size() == 0 && grant == '0)) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_done"}, (exp_beat.size() == 0 && grant == '0), 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
  endtask

  // Downstream slave: samples handshakes at negedge, drives at posedge+1.
  logic        sl_ar_hs, sl_r_hs, sl_rl;
  logic [31:0] sl_cap_addr, sl_addr;
  int          sl_cap_len, sl_len, sl_beat, sl_stall;
  bit          sl_busy;

  initial begin
    si.rvalid = 1'b0; si.rlast = 1'b0; si.rdata = '0; si.rresp = '0;
    sl_busy = 0; sl_addr = '0; sl_len = 0; sl_beat = 0; sl_stall = 0;
    forever begin
      @(negedge clock);
      sl_ar_hs    = si.arvalid && si.arready;
      sl_r_hs     = si.rvalid && si.rready;
      sl_rl       = si.rlast;
      sl_cap_addr = si.araddr;
      sl_cap_len  = int'(si.arlen);
      @(posedge clock); #1;
      if (reset) begin
        sl_busy = 0;
        si.rvalid = 1'b0; si.rlast = 1'b0; si.rdata = '0; si.rresp = '0;
      end else begin
        if (sl_ar_hs) begin
          sl_busy = 1; sl_addr = sl_cap_addr; sl_len = sl_cap_len;
          sl_beat = 0; sl_stall = stall_cfg;
        end else if (sl_busy) begin
          if (sl_r_hs) begin
            if (sl_rl) sl_busy = 0;
            else begin sl_beat++; sl_stall = stall_cfg; end
          end else if (sl_stall > 0) begin
            sl_stall--;
          end
        end
        si.rvalid = sl_busy && (sl_stall == 0);
        si.rlast  = sl_busy && (sl_beat == sl_len || sl_beat == early_last);
        si.rdata  = sl_addr + 32'(sl_beat * 4);
        si.rresp  = 2'(sl_beat);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes an AR or R handshake.
  ar_t        mon_a;
  beat_t      mon_b;
  logic [1:0] mon_v, mon_l;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if ((mi.arready & ~grant) != '0) bad_ready++;
        if (si.arvalid && si.arready) begin
          chk("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) begin
            mon_a = exp_ar.pop_front();
            chk("ar_fields", {grant, si.araddr, si.arlen, si.arsize, si.arburst},
                {2'b01 << mon_a.mst, mon_a.addr, mon_a.len,
                 (mon_a.mst == 0) ? 3'd2 : 3'd3, (mon_a.mst == 0) ? 2'd1 : 2'd2});
            ar_cyc[mon_a.mst] = cyc;
          end
        end
        for (int i = 0; i < NM; i++) begin
          if (mi.rvalid[i] && mi.rready[i]) begin
            chk("r_expected", exp_beat.size() != 0, 1);
            if (exp_beat.size() != 0) begin
              mon_b = exp_beat.pop_front();
              mon_v = 2'b01 << mon_b.mst;
              mon_l = mon_b.last ? mon_v : 2'b00;
              chk("r_beat", {mi.rvalid, mi.rlast, mi.rresp, mi.rdata},
                  {mon_v, mon_l, mon_b.resp, mon_b.data});
            end
            beats_seen[i]++;
            if (mi.rlast[i]) rlast_cyc[i] = cyc;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  int n0;
  int stall_bad;
  int n;

  initial begin
    mi.araddr = '0; mi.arvalid = '0; mi.arlen = '0; mi.arsize = '0; mi.arburst = '0;
    mi.rready = '1;
    si.arready = 1'b0;

    repeat (2) @(negedge clock);
    chk("reset_outputs", {grant, protocol_err, si.arvalid, si.rready, mi.arready, mi.rvalid,
                          mi.rlast, si.araddr, si.arlen, mi.rdata, mi.rresp}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    si.arready = 1'b1;

    // 1: single master, 2 beats, one cycle of arbitration latency
    push_txn(0, 32'h3000_0000, 1, 2, 1);
    set_req(0, 32'h3000_0000, 1);
    @(negedge clock);
    chk("t1_idle_cycle", {si.arvalid, grant}, 0);
    @(negedge clock);
    chk("t1_ar_latency", {si.arvalid, grant, mi.arready, si.araddr, si.arlen},
        {1'b1, 2'b01, 2'b01, 32'h3000_0000, 8'd1});
    @(posedge clock); #1;
    mi.arvalid[0] = 1'b0;
    wait_done("t1");

    // 2: simultaneous requests alternate m0,m1,m0,m1 (second round single-beat)
    apply_reset();
    push_txn(0, 32'h8000_0000, 1, 2, 1);
    push_txn(1, 32'h8000_1000, 1, 2, 1);
    push_txn(0, 32'h8000_2000, 0, 1, 1);
    push_txn(1, 32'h8000_3000, 0, 1, 1);
    fork
      issue(0, 32'h8000_0000, 1);
      issue(1, 32'h8000_1000, 1);
    join
    fork
      issue(0, 32'h8000_2000, 0);
      issue(1, 32'h8000_3000, 0);
    join
    wait_done("t2");

    // 3: m1 waits through a stalled 4-beat m0 burst
    stall_cfg = 2;
    bad_ready = 0;
    push_txn(0, 32'h4000_0100, 3, 4, 1);
    push_txn(1, 32'h4000_0200, 0, 1, 1);
    issue(0, 32'h4000_0100, 3);
    issue(1, 32'h4000_0200, 0);
    wait_done("t3");
    chk("t3_no_foreign_ready", bad_ready, 0);
    chk("t3_ar_after_rlast", ar_cyc[1] - rlast_cyc[0], 2);
    stall_cfg = 0;

    // 4: early rlast on beat 2 of 4 flags a sticky error
    chk("t4_err_clear_before", protocol_err, 0);
    early_last = 1;
    push_txn(0, 32'h5000_0000, 3, 2, 1);
    issue(0, 32'h5000_0000, 3);
    wait_done("t4a");
    chk("t4_err_set", protocol_err, 1);
    early_last = -1;
    push_txn(1, 32'h5000_1000, 0, 1, 1);
    issue(1, 32'h5000_1000, 0);
    wait_done("t4b");
    chk("t4_err_sticky", protocol_err, 1);

    // 5: reset after the first of four beats, then m0 wins the tie
    push_txn(1, 32'h6000_0000, 3, 1, 0);
    n0 = beats_seen[1];
    issue(1, 32'h6000_0000, 3);
    n = 0;
    while (n < 100 && beats_seen[1] == n0) begin
      @(posedge clock); #1;
      n++;
    end
    chk("t5_one_beat", beats_seen[1] - n0, 1);
    reset = 1'b1;
    #1;
    chk("t5_async_reset", {grant, protocol_err, si.arvalid, si.rready, mi.arready,
                           mi.rvalid, mi.rlast}, 0);
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    push_txn(0, 32'h6000_1000, 0, 1, 1);
    push_txn(1, 32'h6000_2000, 0, 1, 1);
    fork
      issue(0, 32'h6000_1000, 0);
      issue(1, 32'h6000_2000, 0);
    join
    wait_done("t5");

    // 6: granted master holds rready low for 3 cycles
    push_txn(0, 32'h7000_0040, 1, 2, 1);
    issue(0, 32'h7000_0040, 1);
    mi.rready[0] = 1'b0;
    stall_bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (si.rready !== 1'b0 || mi.rvalid[0] !== 1'b1 || mi.rdata !== 32'h7000_0040) stall_bad++;
    end
    @(posedge clock); #1;
    mi.rready[0] = 1'b1;
    chk("t6_rready_stall", stall_bad, 0);
    wait_done("t6");
    chk("t6_no_err", protocol_err, 0);

    chk("ar_queue_drained", exp_ar.size(), 0);
    chk("beat_queue_drained", exp_beat.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
